// File: rtl/bp_fe_pkg.sv
// rtl/bp_fe_pkg.sv - shared FE types for the associative loop termination buffer

// Entry layout of one LTB way: {valid, tag, non_spec_cnt, trip_cnt, conf}
`define BP_FE_LTB_ASSOC_ENTRY_S(tag_w, cnt_w, conf_w) \
    typedef struct packed { \
        logic              v; \
        logic [tag_w-1:0]  tag; \
        logic [cnt_w-1:0]  non_spec_cnt; \
        logic [cnt_w-1:0]  trip_cnt; \
        logic [conf_w-1:0] conf; \
    } bp_fe_ltb_assoc_entry_s

package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_reset = 2'd0,
        e_clear = 2'd1,
        e_run   = 2'd2
    } ltb_state_e;

endpackage

// File: rtl/bp_fe_ltb_assoc_replace.sv
// rtl/bp_fe_ltb_assoc_replace.sv - invalid-first / per-set round-robin victim select

module bp_fe_ltb_assoc_replace
    import bp_fe_pkg::*;
#(
    parameter int idx_width_p = 4,
    parameter int ways_p      = 2,
    localparam int lg_ways_lp = (ways_p > 1) ? $clog2(ways_p) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    input  logic [ways_p-1:0]      valid_i,
    input  logic                   hit_i,
    input  logic [idx_width_p-1:0] idx_i,
    output logic [lg_ways_lp-1:0]  way_o
);

    localparam int sets_lp = 1 << idx_width_p;

    logic [lg_ways_lp-1:0] ptr_r [sets_lp];
    logic [lg_ways_lp-1:0] ptr_next;
    logic                  advance;

    // Lowest invalid way wins; only a full set falls back to the pointer
    always_comb begin
        way_o = ptr_r[idx_i];
        for (int w = ways_p - 1; w >= 0; w--) begin
            if (!valid_i[w]) way_o = lg_ways_lp'(w);
        end
    end

    assign advance  = v_i & ~hit_i & (&valid_i);
    assign ptr_next = (ptr_r[idx_i] == lg_ways_lp'(ways_p - 1)) ? '0
                                                                : ptr_r[idx_i] + lg_ways_lp'(1);

    // Pointer moves only when an accepted write evicted a valid way
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < sets_lp; s++) ptr_r[s] <= '0;
        end else if (advance) begin
            ptr_r[idx_i] <= ptr_next;
        end
    end

endmodule

// File: rtl/bp_fe_ltb_assoc.sv
// rtl/bp_fe_ltb_assoc.sv - set-associative loop termination predictor

module bp_fe_ltb_assoc
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int idx_width_p   = 4,
    parameter int tag_width_p   = 10,
    parameter int cnt_width_p   = 8,
    parameter int ways_p        = 2,
    parameter int conf_width_p  = 2,
    parameter int conf_thresh_p = 2,
    localparam int lg_ways_lp   = (ways_p > 1) ? $clog2(ways_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     init_done_o,
    input  logic                     r_v_i,
    input  logic [vaddr_width_p-1:0] r_addr_i,
    input  logic                     r_retry_i,
    output logic                     pred_v_o,
    output logic [lg_ways_lp-1:0]    pred_way_o,
    output logic                     pred_conf_o,
    output logic                     pred_taken_o,
    output logic [cnt_width_p-1:0]   pred_non_spec_cnt_o,
    output logic [cnt_width_p-1:0]   pred_trip_cnt_o,
    input  logic                     w_v_i,
    input  logic [vaddr_width_p-1:0] br_src_addr_i,
    input  logic                     br_taken_i,
    input  logic                     br_mispredict_i,
    input  logic [cnt_width_p-1:0]   br_non_spec_cnt_i,
    output logic                     w_yumi_o
);

    localparam int sets_lp = 1 << idx_width_p;
    localparam logic [conf_width_p-1:0] conf_thresh_lp = conf_width_p'(conf_thresh_p);
    localparam logic [conf_width_p-1:0] conf_max_lp    = '1;

    `BP_FE_LTB_ASSOC_ENTRY_S(tag_width_p, cnt_width_p, conf_width_p);

    bp_fe_ltb_assoc_entry_s mem_r  [sets_lp][ways_p];
    logic [cnt_width_p-1:0] spec_r [sets_lp][ways_p];

    ltb_state_e             state_r;
    logic [idx_width_p-1:0] clr_idx_r;

    // Init sequencer: one reset cycle, then sweep every set to zero
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= e_reset;
            clr_idx_r <= '0;
        end else begin
            case (state_r)
                e_reset: begin
                    state_r   <= e_clear;
                    clr_idx_r <= '0;
                end
                e_clear: begin
                    clr_idx_r <= clr_idx_r + idx_width_p'(1);
                    if (&clr_idx_r) state_r <= e_run;
                end
                default: state_r <= e_run;
            endcase
        end
    end

    assign init_done_o = (state_r == e_run);

    // ---------------- read / speculative path ----------------
    logic [idx_width_p-1:0] r_idx;
    logic [tag_width_p-1:0] r_tag;
    logic                   rd_req, rd_hit, spec_upd;
    logic [ways_p-1:0]      rd_hit_vec;
    logic [lg_ways_lp-1:0]  rd_way;
    bp_fe_ltb_assoc_entry_s rd_entry;
    logic [cnt_width_p-1:0] rd_spec, rd_spec_next;

    assign r_idx  = r_addr_i[2 +: idx_width_p];
    assign r_tag  = r_addr_i[2 + idx_width_p +: tag_width_p];
    assign rd_req = init_done_o & ~reset_i & r_v_i;

    // Same-cycle lookup drives the speculative counter advance
    always_comb begin
        rd_hit_vec = '0;
        rd_way     = '0;
        for (int w = 0; w < ways_p; w++) begin
            if (mem_r[r_idx][w].v && (mem_r[r_idx][w].tag == r_tag)) begin
                rd_hit_vec[w] = 1'b1;
                rd_way        = lg_ways_lp'(w);
            end
        end
    end

    assign rd_hit       = |rd_hit_vec;
    assign rd_entry     = mem_r[r_idx][rd_way];
    assign rd_spec      = spec_r[r_idx][rd_way];
    assign spec_upd     = rd_req & ~r_retry_i & rd_hit;
    // A confident entry that reached its trip count wraps back to zero (loop exit)
    assign rd_spec_next = ((rd_entry.conf >= conf_thresh_lp) && (rd_spec == rd_entry.trip_cnt))
                          ? '0 : rd_spec + cnt_width_p'(1);

    logic                   r_v_r;
    logic [idx_width_p-1:0] r_idx_r;
    logic [tag_width_p-1:0] r_tag_r;
    bp_fe_ltb_assoc_entry_s r_set_r [ways_p];

    // Read-valid flag, cleared by reset so all predictions start at zero
    always_ff @(posedge clk_i) begin
        if (reset_i) r_v_r <= 1'b0;
        else         r_v_r <= rd_req;
    end

    // Capture the addressed set and tag for the prediction cycle
    always_ff @(posedge clk_i) begin
        if (rd_req) begin
            r_idx_r <= r_idx;
            r_tag_r <= r_tag;
            for (int w = 0; w < ways_p; w++) r_set_r[w] <= mem_r[r_idx][w];
        end
    end

    logic [ways_p-1:0]      hit_vec_r;
    logic [lg_ways_lp-1:0]  hit_way_r;
    bp_fe_ltb_assoc_entry_s hit_e;

    // Tag compare against the registered set
    always_comb begin
        hit_vec_r = '0;
        hit_way_r = '0;
        for (int w = 0; w < ways_p; w++) begin
            if (r_set_r[w].v && (r_set_r[w].tag == r_tag_r)) begin
                hit_vec_r[w] = 1'b1;
                hit_way_r    = lg_ways_lp'(w);
            end
        end
    end

    assign hit_e               = r_set_r[hit_way_r];
    assign pred_v_o            = r_v_r & (|hit_vec_r);
    assign pred_way_o          = pred_v_o ? hit_way_r : '0;
    assign pred_conf_o         = pred_v_o & (hit_e.conf >= conf_thresh_lp);
    // Taken follows the counter value after this read's advance
    assign pred_taken_o        = pred_v_o & (spec_r[r_idx_r][hit_way_r] != '0);
    assign pred_non_spec_cnt_o = pred_v_o ? hit_e.non_spec_cnt : '0;
    assign pred_trip_cnt_o     = pred_v_o ? hit_e.trip_cnt : '0;

    // Allocation happens only on miss, so two matching ways means corruption
    always_ff @(posedge clk_i) begin
        if (!reset_i && r_v_r) assert ($onehot0(hit_vec_r));
    end

    // ---------------- training path ----------------
    logic [idx_width_p-1:0] w_idx;
    logic [tag_width_p-1:0] w_tag;
    logic [ways_p-1:0]      w_valid_vec, w_hit_vec;
    logic [lg_ways_lp-1:0]  w_hit_way, rep_way, w_way;
    logic                   w_hit;
    bp_fe_ltb_assoc_entry_s w_old, w_entry;
    logic [cnt_width_p-1:0] w_old_spec, w_spec, w_cnt_inc;

    assign w_idx    = br_src_addr_i[2 +: idx_width_p];
    assign w_tag    = br_src_addr_i[2 + idx_width_p +: tag_width_p];
    // A non-replay read of the same set wins; the write just waits
    assign w_yumi_o = init_done_o & ~reset_i & w_v_i
                    & ~(r_v_i & ~r_retry_i & (r_idx == w_idx));

    // Second combinational read port on the training set
    always_comb begin
        w_valid_vec = '0;
        w_hit_vec   = '0;
        w_hit_way   = '0;
        for (int w = 0; w < ways_p; w++) begin
            w_valid_vec[w] = mem_r[w_idx][w].v;
            if (mem_r[w_idx][w].v && (mem_r[w_idx][w].tag == w_tag)) begin
                w_hit_vec[w] = 1'b1;
                w_hit_way    = lg_ways_lp'(w);
            end
        end
    end

    assign w_hit      = |w_hit_vec;
    assign w_way      = w_hit ? w_hit_way : rep_way;
    assign w_old      = mem_r[w_idx][w_way];
    assign w_old_spec = spec_r[w_idx][w_way];
    assign w_cnt_inc  = br_non_spec_cnt_i + cnt_width_p'(1);

    bp_fe_ltb_assoc_replace #(
        .idx_width_p(idx_width_p),
        .ways_p     (ways_p)
    ) replace (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (w_yumi_o),
        .valid_i(w_valid_vec),
        .hit_i  (w_hit),
        .idx_i  (w_idx),
        .way_o  (rep_way)
    );

    // New entry contents: taken bumps the committed count, not-taken learns the trip
    always_comb begin
        w_entry     = '0;
        w_entry.v   = 1'b1;
        w_entry.tag = w_tag;
        if (br_taken_i) begin
            w_entry.non_spec_cnt = w_cnt_inc;
            w_entry.trip_cnt     = w_hit ? w_old.trip_cnt : '0;
            w_entry.conf         = w_hit ? w_old.conf : '0;
        end else begin
            w_entry.non_spec_cnt = '0;
            w_entry.trip_cnt     = br_non_spec_cnt_i;
            if (w_hit && (w_old.trip_cnt != '0) && (br_non_spec_cnt_i == w_old.trip_cnt))
                w_entry.conf = (w_old.conf == conf_max_lp) ? conf_max_lp
                                                           : w_old.conf + conf_width_p'(1);
            else
                w_entry.conf = '0;
        end
    end

    // Speculative counter repair on resolution
    always_comb begin
        if (br_mispredict_i && !br_taken_i)     w_spec = '0;
        else if (br_mispredict_i && br_taken_i) w_spec = w_cnt_inc;
        else if (!br_taken_i)                   w_spec = w_old_spec - w_cnt_inc;
        else if (!w_hit)                        w_spec = '0;
        else                                    w_spec = w_old_spec;
    end

    // Entry and spec storage: clear sweep, else training write and read advance
    always_ff @(posedge clk_i) begin
        if (state_r == e_clear) begin
            for (int w = 0; w < ways_p; w++) begin
                mem_r[clr_idx_r][w]  <= '0;
                spec_r[clr_idx_r][w] <= '0;
            end
        end else begin
            if (w_yumi_o) begin
                mem_r[w_idx][w_way]  <= w_entry;
                spec_r[w_idx][w_way] <= w_spec;
            end
            if (spec_upd) spec_r[r_idx][rd_way] <= rd_spec_next;
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{r_addr_i, br_src_addr_i};

endmodule

// File: tb/tb_bp_fe_ltb_assoc.sv
// tb/tb_bp_fe_ltb_assoc.sv - directed table-driven bench for bp_fe_ltb_assoc

module tb_bp_fe_ltb_assoc;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        init_done_o;
    logic        r_v_i;
    logic [38:0] r_addr_i;
    logic        r_retry_i;
    logic        pred_v_o;
    logic [0:0]  pred_way_o;
    logic        pred_conf_o;
    logic        pred_taken_o;
    logic [7:0]  pred_non_spec_cnt_o;
    logic [7:0]  pred_trip_cnt_o;
    logic        w_v_i;
    logic [38:0] br_src_addr_i;
    logic        br_taken_i;
    logic        br_mispredict_i;
    logic [7:0]  br_non_spec_cnt_i;
    logic        w_yumi_o;

    always #5 clk_i = ~clk_i;

    bp_fe_ltb_assoc dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .init_done_o        (init_done_o),
        .r_v_i              (r_v_i),
        .r_addr_i           (r_addr_i),
        .r_retry_i          (r_retry_i),
        .pred_v_o           (pred_v_o),
        .pred_way_o         (pred_way_o),
        .pred_conf_o        (pred_conf_o),
        .pred_taken_o       (pred_taken_o),
        .pred_non_spec_cnt_o(pred_non_spec_cnt_o),
        .pred_trip_cnt_o    (pred_trip_cnt_o),
        .w_v_i              (w_v_i),
        .br_src_addr_i      (br_src_addr_i),
        .br_taken_i         (br_taken_i),
        .br_mispredict_i    (br_mispredict_i),
        .br_non_spec_cnt_i  (br_non_spec_cnt_i),
        .w_yumi_o           (w_yumi_o)
    );

    typedef struct {
        bit          is_wr;
        logic [38:0] addr;
        bit          retry;
        bit          taken;
        bit          misp;
        logic [7:0]  cnt;
        bit          e_v;
        bit          e_way;
        bit          e_conf;
        bit          e_taken;
        logic [7:0]  e_nsc;
        logic [7:0]  e_trip;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t wr(input logic [38:0] a, input bit tk, input bit mp, input logic [7:0] c);
        vec_t v;
        v = '{default: '0};
        v.is_wr = 1'b1; v.addr = a; v.taken = tk; v.misp = mp; v.cnt = c;
        return v;
    endfunction

    function automatic vec_t rd(input logic [38:0] a, input bit rt, input bit ev, input bit ew,
                                input bit ec, input bit et, input logic [7:0] en, input logic [7:0] etr);
        vec_t v;
        v = '{default: '0};
        v.addr = a; v.retry = rt; v.e_v = ev; v.e_way = ew; v.e_conf = ec;
        v.e_taken = et; v.e_nsc = en; v.e_trip = etr;
        return v;
    endfunction

    task automatic do_write(input logic [38:0] a, input bit tk, input bit mp, input logic [7:0] c);
        bit done;
        done = 1'b0;
        @(negedge clk_i);
        w_v_i = 1'b1; br_src_addr_i = a; br_taken_i = tk; br_mispredict_i = mp; br_non_spec_cnt_i = c;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (w_yumi_o) done = 1'b1;
            @(posedge clk_i);
            if (done) break;
            @(negedge clk_i);
        end
        #1 w_v_i = 1'b0;
        chk("wr_accept", done, 1);
    endtask

    task automatic do_read(input logic [38:0] a, input bit rt);
        @(negedge clk_i);
        r_v_i = 1'b1; r_addr_i = a; r_retry_i = rt;
        @(posedge clk_i);
        #1;
        r_v_i = 1'b0; r_retry_i = 1'b0;
    endtask

    task automatic count_init(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk_i);
            #1;
            n++;
            if (init_done_o) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit saw_pred;

        reset_i = 1'b1; r_v_i = 1'b0; r_addr_i = '0; r_retry_i = 1'b0;
        w_v_i = 1'b0; br_src_addr_i = '0; br_taken_i = 1'b0; br_mispredict_i = 1'b0;
        br_non_spec_cnt_i = '0;

        // Test 1: reset state and init latency with reads held during clear
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_init_done", init_done_o, 0);
        chk("rst_pred_v", pred_v_o, 0);
        chk("rst_pred_taken", pred_taken_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0; r_v_i = 1'b1; r_addr_i = 39'h1000;
        n = 0; saw_pred = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk_i);
            #1;
            n++;
            if (pred_v_o) saw_pred = 1'b1;
            if (init_done_o) break;
        end
        r_v_i = 1'b0;
        chk("init_cycles", n, 17);
        chk("pre_init_pred_v", saw_pred, 0);

        // Test 6a: reset in the middle of the clear sweep restarts it
        @(negedge clk_i); reset_i = 1'b1;
        @(negedge clk_i); reset_i = 1'b0;
        repeat (7) @(posedge clk_i);
        @(negedge clk_i); reset_i = 1'b1;
        @(posedge clk_i); #1;
        chk("midclr_init_done", init_done_o, 0);
        @(negedge clk_i); reset_i = 1'b0;
        count_init(n);
        chk("midclr_init_cycles", n, 17);

        // Tests 2, 3: loop training / prediction and replacement
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 5; c++) tbl.push_back(wr(39'h1000, 1, 0, 8'(c)));
            tbl.push_back(wr(39'h1000, 0, 1, 8'd5));
        end
        for (int k = 0; k < 5; k++) tbl.push_back(rd(39'h1000, 0, 1, 0, 1, 1, 8'd0, 8'd5));
        tbl.push_back(rd(39'h1000, 1, 1, 0, 1, 1, 8'd0, 8'd5));
        tbl.push_back(rd(39'h1000, 0, 1, 0, 1, 0, 8'd0, 8'd5));
        tbl.push_back(rd(39'h1000, 0, 1, 0, 1, 1, 8'd0, 8'd5));
        tbl.push_back(wr(39'h200C, 1, 0, 8'd0));
        tbl.push_back(wr(39'h204C, 1, 0, 8'd0));
        tbl.push_back(rd(39'h200C, 0, 1, 0, 0, 1, 8'd1, 8'd0));
        tbl.push_back(rd(39'h204C, 0, 1, 1, 0, 1, 8'd1, 8'd0));
        tbl.push_back(wr(39'h208C, 1, 0, 8'd2));
        tbl.push_back(rd(39'h208C, 0, 1, 0, 0, 1, 8'd3, 8'd0));
        tbl.push_back(rd(39'h200C, 0, 0, 0, 0, 0, 8'd0, 8'd0));
        tbl.push_back(rd(39'h204C, 0, 1, 1, 0, 1, 8'd1, 8'd0));
        tbl.push_back(wr(39'h200C, 1, 0, 8'd0));
        tbl.push_back(rd(39'h200C, 0, 1, 1, 0, 1, 8'd1, 8'd0));
        tbl.push_back(rd(39'h204C, 0, 0, 0, 0, 0, 8'd0, 8'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_wr) begin
                do_write(tbl[i].addr, tbl[i].taken, tbl[i].misp, tbl[i].cnt);
            end else begin
                do_read(tbl[i].addr, tbl[i].retry);
                chk($sformatf("row%0d_v", i), pred_v_o, tbl[i].e_v);
                chk($sformatf("row%0d_way", i), pred_way_o, tbl[i].e_way);
                chk($sformatf("row%0d_conf", i), pred_conf_o, tbl[i].e_conf);
                chk($sformatf("row%0d_taken", i), pred_taken_o, tbl[i].e_taken);
                chk($sformatf("row%0d_nsc", i), pred_non_spec_cnt_o, tbl[i].e_nsc);
                chk($sformatf("row%0d_trip", i), pred_trip_cnt_o, tbl[i].e_trip);
            end
        end

        // Test 4: same-set read blocks training; replay and other-set reads do not
        @(negedge clk_i);
        r_v_i = 1'b1; r_addr_i = 39'h2014; r_retry_i = 1'b0;
        w_v_i = 1'b1; br_src_addr_i = 39'h2014; br_taken_i = 1'b1; br_mispredict_i = 1'b0;
        br_non_spec_cnt_i = 8'd7;
        #1 chk("blk_same_set", w_yumi_o, 0);
        @(negedge clk_i); r_v_i = 1'b0;
        #1 chk("blk_release", w_yumi_o, 1);
        @(posedge clk_i); #1 w_v_i = 1'b0;
        do_read(39'h2014, 0);
        chk("blk_v", pred_v_o, 1);
        chk("blk_nsc", pred_non_spec_cnt_o, 8);
        chk("blk_way", pred_way_o, 0);
        @(negedge clk_i);
        r_v_i = 1'b1; r_addr_i = 39'h2018;
        w_v_i = 1'b1; br_non_spec_cnt_i = 8'd9;
        #1 chk("diff_set_yumi", w_yumi_o, 1);
        @(posedge clk_i); #1 r_v_i = 1'b0; w_v_i = 1'b0;
        @(negedge clk_i);
        r_v_i = 1'b1; r_addr_i = 39'h2014; r_retry_i = 1'b1;
        w_v_i = 1'b1; br_non_spec_cnt_i = 8'd11;
        #1 chk("retry_same_set_yumi", w_yumi_o, 1);
        @(posedge clk_i); #1 r_v_i = 1'b0; r_retry_i = 1'b0; w_v_i = 1'b0;
        do_read(39'h2014, 0);
        chk("retry_wr_nsc", pred_non_spec_cnt_o, 12);

        // Test 5: early exit on a confident entry drops confidence
        do_write(39'h1000, 0, 1, 8'd3);
        do_read(39'h1000, 0);
        chk("exit_v", pred_v_o, 1);
        chk("exit_conf", pred_conf_o, 0);
        chk("exit_trip", pred_trip_cnt_o, 3);
        chk("exit_nsc", pred_non_spec_cnt_o, 0);

        // Test 6b: reset in run drops accept at once and wipes the table
        do_read(39'h1000, 0);
        chk("run_hit_before_rst", pred_v_o, 1);
        @(negedge clk_i);
        reset_i = 1'b1; w_v_i = 1'b1; br_src_addr_i = 39'h1000; br_taken_i = 1'b1;
        #1 chk("rst_yumi_drop", w_yumi_o, 0);
        @(posedge clk_i); #1;
        chk("runrst_pred_v", pred_v_o, 0);
        chk("runrst_init_done", init_done_o, 0);
        @(negedge clk_i); reset_i = 1'b0; w_v_i = 1'b0;
        count_init(n);
        chk("runrst_init_cycles", n, 17);
        do_read(39'h1000, 0);
        chk("runrst_entry_gone", pred_v_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
